alu_cmd_ctrl: RTL and testbench
===============================

# alu_cmd_ctrl

Initiator-side controller for the power-gated 16-bit ALU. It accepts operation requests on a valid/ready port and sequences the ALU power domain: power-up, isolation release, idle timeout, isolation and power-down. It drives the ALU start/opcode/operand interface, waits out the multi-cycle multiply and divide, and returns the result on a valid/ready response port. It sits between the command fabric and the ALU instance.

## Interface
- DATA_W, 16, operand/result width (must match the ALU)
- PWR_UP_CYC, 4, cycles with power on and isolation held before first issue (≥1)
- IDLE_TIMEOUT, 32, consecutive idle cycles in READY before automatic power-down (≥1)
- WDOG_CYC, 16, maximum cycles to wait for alu_busy to drop
- clk  in  1  system clock, all logic posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_op  in  4  opcode (0–7 single-cycle, 8 MUL, 9 DIV)
- req_a, req_b  in  DATA_W  operands
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_data  out  DATA_W  result
- rsp_err  out  1  illegal opcode, divide-by-zero or watchdog expiry
- sleep_req  in  1  force power-down at next idle point
- alu_pwr_en  out  1  ALU domain power enable
- iso_en  out  1  ALU output isolation
- alu_start, alu_opcode[3:0], alu_a, alu_b  out  ALU command
- alu_result  in  DATA_W, alu_busy  in  1  ALU status

## Operation
- Reset values: alu_pwr_en=0, iso_en=1, alu_start=0, alu_opcode/a/b=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0. State = OFF.
- States: OFF, PWR_UP, READY, ISSUE, WAIT, RESP, PWR_DN.
- OFF: pwr_en=0, iso=1. req_ready=1 unless sleep_req=1. On accept: latch op/a/b, go to PWR_UP.
- PWR_UP: pwr_en=1, iso=1 for exactly PWR_UP_CYC cycles. Then go to ISSUE if a request is latched, else READY.
- READY: pwr_en=1, iso=0, req_ready=1. On accept: latch, go to ISSUE. If sleep_req=1 or the idle counter reaches IDLE_TIMEOUT, go to PWR_DN. Acceptance wins over timeout in the same cycle.
- Illegal op (10–15) or op 9 with req_b=0 is short-circuited: no ALU issue, go directly to RESP with rsp_data=0, rsp_err=1.
- ISSUE: alu_start=1 for one cycle, then WAIT.
- alu_opcode/a/b are driven from the latched registers and held constant from ISSUE through WAIT. The ALU samples the operands at completion.
- WAIT: capture alu_result at the first cycle with alu_busy=0, with rsp_err=0, then go to RESP. This single rule covers single-cycle ops, where busy never rises, and MUL/DIV.
- Watchdog: if WAIT lasts WDOG_CYC cycles, respond with data 0 and err=1.
- RESP: rsp_valid=1 with data/err stable until rsp_ready. Then go to READY and clear the idle counter. Requests are not accepted while in RESP.
- PWR_DN: iso=1, pwr_en=1 for one cycle, then OFF (pwr_en=0). iso_en is never 0 while pwr_en=0.
- Power is never removed, and isolation never asserted, in ISSUE/WAIT/RESP. sleep_req is honoured only in READY.

## Timing
- Single-cycle op from READY: accept edge at cycle 0, start in cycle 1, capture in cycle 2, rsp_valid in cycle 3.
- MUL: busy is high in cycles 2–6, capture in cycle 7, rsp_valid in cycle 8.
- DIV: busy is high in cycles 2–10, capture in cycle 11, rsp_valid in cycle 12.
- From OFF, add PWR_UP_CYC cycles.
- Back-to-back requests: next accept is possible the cycle after the rsp handshake.
- Reset mid-operation returns immediately to OFF with the reset values. Any in-flight result is discarded.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD…OP_XNOR, OP_MUL=4'h8, OP_DIV=4'h9)
  - the controller state enum
  - DATA_W default
- Sub-module alu_pwr_seq holds the PWR_UP/PWR_DN counters and the pwr_en/iso_en sequencing, with pwr_ready and pwr_off status outputs.

## Test plan
- Reset, then req op=0, a=3, b=5 → power-up for 4 cycles; rsp_data=8, err=0; pwr_en=1 and iso_en=0 by the start cycle.
- From READY, op=8, a=300, b=7 → rsp_valid exactly 8 cycles after accept, data=2100; operands held through WAIT.
- op=9, a=100, b=0 → no alu_start pulse; rsp_data=0, err=1. op=9, a=100, b=7 → data=14 at cycle 12.
- op=12 → err=1, data=0. Then hold rsp_ready=0 for 5 cycles → rsp_valid and data stable, req_ready=0.
- No requests for 32 cycles in READY → iso_en rises one cycle before pwr_en falls. Next request re-runs power-up.
- Force alu_busy stuck high → err=1 after 16 WAIT cycles. Assert rst during WAIT of a DIV → all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state enums and helpers for the power-gated ALU controller
// Ports: none (package).
package alu_pkg;

  // Default operand/result width; must match the ALU instance.
  localparam int ALU_DATA_W = 16;

  // Single-cycle opcodes 0-7, multi-cycle 8-9; 10-15 are illegal.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;

  // Cycles spent in PWR_DN with isolation on before power is removed.
  localparam int PWR_DN_CYC = 1;

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_READY,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_PWR_DN
  } ctrl_state_e;

  // Power-domain phase as seen by the sequencer.
  typedef enum logic [1:0] {
    PM_OFF,
    PM_UP,
    PM_ON,
    PM_DN
  } pwr_mode_e;

  // Requests answered with err=1 without touching the ALU.
  function automatic logic op_rejected(input logic [3:0] op, input logic b_zero);
    return (op > OP_DIV) || ((op == OP_DIV) && b_zero);
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// rtl/alu_cmd_ctrl_if.sv - request/response handshake bundle between command fabric and ALU controller
// Signals: req_valid/req_ready/req_op/req_a/req_b (request), rsp_valid/rsp_ready/rsp_data/rsp_err (response).
// Modports: master = fabric side, slave = controller side.
interface alu_cmd_ctrl_if #(
  parameter int DATA_W = alu_pkg::ALU_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_pwr_seq.sv
// rtl/alu_pwr_seq.sv - ALU power-enable / isolation sequencer with power-up and power-down counters
// Ports: clk, rst (async, active-high); mode_nxt (phase the controller enters next cycle);
//        pwr_en, iso_en (registered domain controls); pwr_ready (last PWR_UP cycle);
//        pwr_off (last PWR_DN cycle).
module alu_pwr_seq
  import alu_pkg::*;
#(
  parameter int PWR_UP_CYC = 4
)(
  input  logic      clk,
  input  logic      rst,
  input  pwr_mode_e mode_nxt,
  output logic      pwr_en,
  output logic      iso_en,
  output logic      pwr_ready,
  output logic      pwr_off
);
  localparam int CNT_MAX = (PWR_UP_CYC > PWR_DN_CYC) ? PWR_UP_CYC : PWR_DN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  pwr_mode_e        mode;
  logic [CNT_W-1:0] cnt;

  // pwr_en/iso_en are registered from the upcoming phase so they are glitch-free
  // and change on the same edge the controller changes state. Isolation is off
  // only in PM_ON, so iso_en is always 1 whenever pwr_en is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode   <= PM_OFF;
      cnt    <= '0;
      pwr_en <= 1'b0;
      iso_en <= 1'b1;
    end else begin
      mode   <= mode_nxt;
      pwr_en <= (mode_nxt != PM_OFF);
      iso_en <= (mode_nxt != PM_ON);
      if (mode_nxt != mode) begin
        cnt <= '0;
      end else if ((mode == PM_UP) || (mode == PM_DN)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign pwr_ready = (mode == PM_UP) && (cnt == CNT_W'(PWR_UP_CYC - 1));
  assign pwr_off   = (mode == PM_DN) && (cnt == CNT_W'(PWR_DN_CYC - 1));

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - initiator-side controller sequencing power and commands for the gated 16-bit ALU
// Ports: clk, rst (async, active-high); cmd (alu_cmd_ctrl_if.slave: request/response handshakes);
//        sleep_req (power down at next idle point); alu_pwr_en, iso_en (power domain);
//        alu_start, alu_opcode, alu_a, alu_b (ALU command); alu_result, alu_busy (ALU status).
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W       = ALU_DATA_W,
  parameter int PWR_UP_CYC   = 4,
  parameter int IDLE_TIMEOUT = 32,
  parameter int WDOG_CYC     = 16
)(
  input  logic              clk,
  input  logic              rst,
  alu_cmd_ctrl_if.slave     cmd,
  input  logic              sleep_req,
  output logic              alu_pwr_en,
  output logic              iso_en,
  output logic              alu_start,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_busy
);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);

  ctrl_state_e       state, state_nxt;
  pwr_mode_e         mode_nxt;
  logic              pwr_ready, pwr_off;
  logic [3:0]        op_r;
  logic [DATA_W-1:0] a_r, b_r;
  logic              bad_r;
  logic [DATA_W-1:0] data_r;
  logic              err_r;
  logic              rdy_r;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              accept;
  logic              req_bad;

  // rdy_r is a registered decode of "state is OFF or READY"; registering it
  // keeps req_ready low while rst is asserted even though OFF would otherwise
  // advertise readiness.
  assign cmd.req_ready = rdy_r && !((state == S_OFF) && sleep_req);
  assign accept        = cmd.req_valid && cmd.req_ready;
  assign req_bad       = op_rejected(cmd.req_op, cmd.req_b == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OFF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:    if (accept) state_nxt = S_PWR_UP;
      // PWR_UP is only entered from an accept in OFF, so a request is always latched here.
      S_PWR_UP: if (pwr_ready) state_nxt = bad_r ? S_RESP : S_ISSUE;
      S_READY: begin
        if (accept) begin
          state_nxt = req_bad ? S_RESP : S_ISSUE;
        end else if (sleep_req || (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1))) begin
          state_nxt = S_PWR_DN;
        end
      end
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (!alu_busy || (wdog_cnt == WDOG_W'(WDOG_CYC - 1))) state_nxt = S_RESP;
      S_RESP:   if (cmd.rsp_ready) state_nxt = S_READY;
      S_PWR_DN: if (pwr_off) state_nxt = S_OFF;
      default:  state_nxt = S_OFF;
    endcase
  end

  always_comb begin
    mode_nxt = PM_ON;
    case (state_nxt)
      S_OFF:    mode_nxt = PM_OFF;
      S_PWR_UP: mode_nxt = PM_UP;
      S_PWR_DN: mode_nxt = PM_DN;
      default:  mode_nxt = PM_ON;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      bad_r    <= 1'b0;
      data_r   <= '0;
      err_r    <= 1'b0;
      rdy_r    <= 1'b0;
      idle_cnt <= '0;
      wdog_cnt <= '0;
    end else begin
      rdy_r <= (state_nxt == S_OFF) || (state_nxt == S_READY);
      // Operands only change on accept, so they stay constant through ISSUE/WAIT.
      if (accept) begin
        op_r  <= cmd.req_op;
        a_r   <= cmd.req_a;
        b_r   <= cmd.req_b;
        bad_r <= req_bad;
      end
      // Response is loaded once on entry to RESP and then held until the handshake.
      if ((state != S_RESP) && (state_nxt == S_RESP)) begin
        if ((state == S_WAIT) && !alu_busy) begin
          data_r <= alu_result;
          err_r  <= 1'b0;
        end else begin
          data_r <= '0;
          err_r  <= 1'b1;
        end
      end
      idle_cnt <= ((state == S_READY) && (state_nxt == S_READY)) ? idle_cnt + IDLE_W'(1) : '0;
      wdog_cnt <= ((state == S_WAIT) && (state_nxt == S_WAIT)) ? wdog_cnt + WDOG_W'(1) : '0;
    end
  end

  alu_pwr_seq #(
    .PWR_UP_CYC (PWR_UP_CYC)
  ) u_pwr_seq (
    .clk       (clk),
    .rst       (rst),
    .mode_nxt  (mode_nxt),
    .pwr_en    (alu_pwr_en),
    .iso_en    (iso_en),
    .pwr_ready (pwr_ready),
    .pwr_off   (pwr_off)
  );

  assign alu_start     = (state == S_ISSUE);
  assign alu_opcode    = op_r;
  assign alu_a         = a_r;
  assign alu_b         = b_r;
  assign cmd.rsp_valid = (state == S_RESP);
  assign cmd.rsp_data  = data_r;
  assign cmd.rsp_err   = err_r;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed self-checking bench for alu_cmd_ctrl with a behavioural ALU
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sleep_req = 1'b0;
  logic        alu_pwr_en, iso_en, alu_start, alu_busy;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        stuck = 1'b0;
  int          busy_cnt;
  int          starts = 0;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          s0;

  alu_cmd_ctrl_if #(.DATA_W(16)) cmd();

  alu_cmd_ctrl #(
    .DATA_W(16), .PWR_UP_CYC(4), .IDLE_TIMEOUT(32), .WDOG_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .sleep_req  (sleep_req),
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .alu_start  (alu_start),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_busy   (alu_busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: MUL busy 5 cycles, DIV busy 9 cycles, others combinational.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_MUL:  return a * b;
      OP_DIV:  return (b == 16'd0) ? 16'd0 : a / b;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                   busy_cnt <= 0;
    else if (alu_start)        busy_cnt <= (alu_opcode == OP_MUL) ? 5 : (alu_opcode == OP_DIV) ? 9 : 0;
    else if (busy_cnt > 0)     busy_cnt <= busy_cnt - 1;
  end
  assign alu_busy = stuck || (busy_cnt != 0);
  always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b);

  always @(posedge clk) if (alu_start) starts <= starts + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents one request; the accept edge ends the current cycle, so cyc=1 afterwards.
  task automatic send(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    cmd.req_valid = 1'b1;
    cmd.req_op    = op;
    cmd.req_a     = a;
    cmd.req_b     = b;
    check({tag, "_req_ready"}, 64'(cmd.req_ready), 64'd1);
    @(posedge clk);
    #1;
    cyc = 1;
    cmd.req_valid = 1'b0;
  endtask

  task automatic await_rsp(input string tag, input int exp_cyc, input logic [15:0] exp_data,
                           input logic exp_err, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    while (!cmd.rsp_valid && cyc < 64) begin
      if (cyc >= 2) check({tag, "_hold"}, 64'({alu_opcode, alu_a, alu_b}), 64'({op, a, b}));
      tick();
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_data"}, 64'(cmd.rsp_data), 64'(exp_data));
    check({tag, "_err"}, 64'(cmd.rsp_err), 64'(exp_err));
  endtask

  task automatic handshake();
    cmd.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd.rsp_ready = 1'b0;
    cyc = 1;
  endtask

  initial begin
    cmd.req_valid = 1'b0;
    cmd.req_op    = 4'h0;
    cmd.req_a     = 16'h0;
    cmd.req_b     = 16'h0;
    cmd.rsp_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_ctrl", 64'({alu_pwr_en, iso_en, alu_start, cmd.req_ready, cmd.rsp_valid, cmd.rsp_err}), 64'(6'b010000));
    check("rst_bus", 64'({alu_opcode, alu_a, alu_b, cmd.rsp_data}), 64'd0);
    rst = 1'b0;
    tick();

    // ADD from OFF: 4 power-up cycles, issue in cycle 5, response in cycle 7
    send("add", OP_ADD, 16'd3, 16'd5);
    check("add_pwrup_c1", 64'({alu_pwr_en, iso_en, alu_start}), 64'(3'b110));
    tick(); tick(); tick();
    check("add_pwrup_c4", 64'({alu_pwr_en, iso_en, alu_start}), 64'(3'b110));
    tick();
    check("add_start_c5", 64'({alu_pwr_en, iso_en, alu_start}), 64'(3'b101));
    await_rsp("add", 7, 16'd8, 1'b0, OP_ADD, 16'd3, 16'd5);
    handshake();

    // MUL from READY: response 8 cycles after accept
    s0 = starts;
    send("mul", OP_MUL, 16'd300, 16'd7);
    await_rsp("mul", 8, 16'd2100, 1'b0, OP_MUL, 16'd300, 16'd7);
    check("mul_starts", 64'(starts), 64'(s0 + 1));
    handshake();

    // DIV by zero short-circuits without an ALU start
    s0 = starts;
    send("div0", OP_DIV, 16'd100, 16'd0);
    await_rsp("div0", 1, 16'd0, 1'b1, OP_DIV, 16'd100, 16'd0);
    handshake();
    check("div0_no_start", 64'(starts), 64'(s0));

    // DIV: response at cycle 12
    send("div", OP_DIV, 16'd100, 16'd7);
    await_rsp("div", 12, 16'd14, 1'b0, OP_DIV, 16'd100, 16'd7);
    handshake();

    // Illegal opcode, then stall the response for 5 cycles with a competing request
    send("ill", 4'd12, 16'd1, 16'd2);
    await_rsp("ill", 1, 16'd0, 1'b1, 4'd12, 16'd1, 16'd2);
    cmd.req_valid = 1'b1;
    cmd.req_op    = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rsp", 64'({cmd.rsp_valid, cmd.rsp_err, cmd.rsp_data, cmd.req_ready}), 64'({1'b1, 1'b1, 16'd0, 1'b0}));
    end
    cmd.req_valid = 1'b0;
    handshake();

    // Accept on the idle-timeout cycle wins over power-down
    while (cyc < 32) tick();
    send("tmo_acc", OP_AND, 16'hF0F0, 16'h0FF0);
    await_rsp("tmo_acc", 3, 16'h00F0, 1'b0, OP_AND, 16'hF0F0, 16'h0FF0);
    handshake();

    // Idle timeout: READY cycles 1..32, PWR_DN in 33, OFF in 34
    while (cyc < 32) tick();
    check("idle_c32", 64'({alu_pwr_en, iso_en}), 64'(2'b10));
    tick();
    check("idle_pwrdn", 64'({alu_pwr_en, iso_en}), 64'(2'b11));
    tick();
    check("idle_off", 64'({alu_pwr_en, iso_en}), 64'(2'b01));

    // Next request re-runs power-up
    send("sub", OP_SUB, 16'd10, 16'd3);
    tick(); tick(); tick();
    check("sub_pwrup_c4", 64'({alu_pwr_en, iso_en}), 64'(2'b11));
    await_rsp("sub", 7, 16'd7, 1'b0, OP_SUB, 16'd10, 16'd3);
    handshake();

    // sleep_req from READY powers down; OFF refuses requests while it is held
    sleep_req = 1'b1;
    tick();
    check("sleep_pwrdn", 64'({alu_pwr_en, iso_en}), 64'(2'b11));
    tick();
    check("sleep_off", 64'({alu_pwr_en, iso_en, cmd.req_ready}), 64'(3'b010));
    sleep_req = 1'b0;
    #1;
    check("sleep_release_rdy", 64'(cmd.req_ready), 64'd1);

    // Stuck busy from OFF: ISSUE in 5, 16 WAIT cycles 6..21, watchdog response in 22
    stuck = 1'b1;
    send("wdog", OP_MUL, 16'd2, 16'd2);
    await_rsp("wdog", 22, 16'd0, 1'b1, OP_MUL, 16'd2, 16'd2);
    stuck = 1'b0;
    handshake();

    // Reset during DIV WAIT discards the operation
    send("divrst", OP_DIV, 16'd100, 16'd7);
    tick(); tick(); tick(); tick();
    check("divrst_in_wait", 64'({alu_busy, cmd.rsp_valid}), 64'(2'b10));
    rst = 1'b1;
    tick();
    check("divrst_ctrl", 64'({alu_pwr_en, iso_en, alu_start, cmd.req_ready, cmd.rsp_valid, cmd.rsp_err}), 64'(6'b010000));
    check("divrst_bus", 64'({alu_opcode, alu_a, alu_b, cmd.rsp_data}), 64'd0);
    rst = 1'b0;
    tick();

    // Normal operation after reset
    send("xor", OP_XOR, 16'h00FF, 16'h0F0F);
    await_rsp("xor", 7, 16'h0FF0, 1'b0, OP_XOR, 16'h00FF, 16'h0F0F);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
